// File: rtl/vga_pkg.sv
// vga_pkg: VGA timing constants and the vblank arbiter state encoding.
// Shared by the sync generator and the vblank access arbiter.
package vga_pkg;

    localparam int HD      = 640;
    localparam int H_TOTAL = 800;
    localparam int VD      = 480;
    localparam int V_TOTAL = 525;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2
    } arb_state_t;

    // Access window: first blank line up to the guard band before wrap.
    function automatic logic in_vblank_window(
        input logic [9:0] y,
        input int         vd,
        input int         vtot,
        input int         guard
    );
        int yi;
        yi = int'(y);
        return (yi >= vd) && (yi < vtot - guard);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// Returns the first set request at or after ptr, searching cyclically.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_pick,
    output logic          o_valid
);

    logic [N-1:0] w_rot;
    logic [N-1:0] w_lo;

    // Rotate requests so that position ptr lands on bit 0.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < N; i++) begin
            w_rot[i] = i_req[PW'((i + int'(i_ptr)) % N)];
        end
    end

    // Lowest set bit of the rotated vector is the winner.
    assign w_lo = w_rot & (~w_rot + N'(1));

    // Rotate the one-hot winner back to requester numbering.
    always_comb begin
        o_pick = '0;
        for (int i = 0; i < N; i++) begin
            o_pick[PW'((i + int'(i_ptr)) % N)] = w_lo[i];
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/vblank_access_arbiter.sv
// vblank_access_arbiter: round-robin access grants that are only issued
// during vertical blanking, with hold timeout and frame counter.
module vblank_access_arbiter #(
    parameter int N_REQ       = 4,
    parameter int VD          = vga_pkg::VD,
    parameter int V_TOTAL     = vga_pkg::V_TOTAL,
    parameter int GUARD_LINES = 2,
    parameter int MAX_HOLD    = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       pixely,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic             window,
    output logic             busy,
    output logic             timeout,
    output logic             revoked,
    output logic [7:0]       frame_cnt
);
    import vga_pkg::*;

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);
    localparam logic [HW-1:0] HOLD_END = HW'(MAX_HOLD - 1);

    arb_state_t       r_state;
    logic [N_REQ-1:0] r_grant;
    logic [PW-1:0]    r_gidx;
    logic [PW-1:0]    r_ptr;
    logic [HW-1:0]    r_hold;
    logic             r_window;
    logic             r_timeout;
    logic             r_revoked;
    logic [7:0]       r_frame;

    logic             w_win_cond;
    logic [N_REQ-1:0] w_pick;
    logic             w_pick_vld;
    logic [PW-1:0]    w_pick_idx;
    logic [PW-1:0]    w_next_ptr;

    assign w_win_cond = in_vblank_window(pixely, VD, V_TOTAL, GUARD_LINES);

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_valid (w_pick_vld)
    );

    // Encode the one-hot pick into the grantee index.
    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) w_pick_idx = PW'(i);
        end
    end

    assign w_next_ptr = (r_gidx == LAST_IDX) ? '0 : r_gidx + PW'(1);

    // Register the window and count frames on its rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_window <= 1'b0;
            r_frame  <= '0;
        end else begin
            r_window <= w_win_cond;
            if (w_win_cond && !r_window) r_frame <= r_frame + 8'd1;
        end
    end

    // Arbitration FSM with hold counter, pointer and release pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= WAIT;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
            r_revoked <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            r_revoked <= 1'b0;
            unique case (r_state)
                WAIT: begin
                    if (r_window) r_state <= ARB;
                end
                ARB: begin
                    if (!r_window) begin
                        r_state <= WAIT;
                    end else if (w_pick_vld) begin
                        r_grant <= w_pick;
                        r_gidx  <= w_pick_idx;
                        r_hold  <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!r_window) begin
                        r_grant   <= '0;
                        r_revoked <= 1'b1;
                        r_ptr     <= w_next_ptr;
                        r_state   <= WAIT;
                    end else if (done[r_gidx] || !req[r_gidx]) begin
                        r_grant <= '0;
                        r_ptr   <= w_next_ptr;
                        r_state <= ARB;
                    end else if (r_hold == HOLD_END) begin
                        r_grant   <= '0;
                        r_timeout <= 1'b1;
                        r_ptr     <= w_next_ptr;
                        r_state   <= ARB;
                    end else begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= WAIT;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign window    = r_window;
    assign busy      = |r_grant;
    assign timeout   = r_timeout;
    assign revoked   = r_revoked;
    assign frame_cnt = r_frame;

endmodule

// File: tb/tb_vblank_access_arbiter.sv
// tb_vblank_access_arbiter: directed table, corner sequences and
// randomized traffic against a behavioural reference model.
module tb_vblank_access_arbiter;

    localparam int N  = 4;
    localparam int MH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] pixely;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic       window;
    logic       busy;
    logic       timeout;
    logic       revoked;
    logic [7:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vblank_access_arbiter #(
        .N_REQ       (N),
        .VD          (480),
        .V_TOTAL     (525),
        .GUARD_LINES (2),
        .MAX_HOLD    (MH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pixely    (pixely),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .window    (window),
        .busy      (busy),
        .timeout   (timeout),
        .revoked   (revoked),
        .frame_cnt (frame_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: owner index, age of the grant, search pointer,
    // and whether arbitration has been armed by an observed open window.
    int m_owner, m_age, m_ptr, m_frames;
    bit m_win, m_can, m_to, m_rv;

    function automatic void model_reset();
        m_owner  = -1;
        m_age    = 0;
        m_ptr    = 0;
        m_frames = 0;
        m_win    = 0;
        m_can    = 0;
        m_to     = 0;
        m_rv     = 0;
    endfunction

    function automatic void model_release();
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
    endfunction

    function automatic void model_step();
        int py;
        bit pw;
        bit cond;
        bit found;
        py    = int'(pixely);
        pw    = m_win;
        cond  = (py >= 480) && (py < 523);
        m_to  = 0;
        m_rv  = 0;
        found = 0;
        if (m_owner >= 0) begin
            if (!pw) begin
                m_rv  = 1;
                m_can = 0;
                model_release();
            end else if (done[m_owner] || !req[m_owner]) begin
                model_release();
            end else if (m_age == MH - 1) begin
                m_to = 1;
                model_release();
            end else begin
                m_age++;
            end
        end else if (!m_can) begin
            m_can = pw;
        end else if (!pw) begin
            m_can = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (!found && req[idx]) begin
                    found   = 1;
                    m_owner = idx;
                    m_age   = 0;
                end
            end
        end
        if (cond && !pw) m_frames = (m_frames + 1) % 256;
        m_win = cond;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else model_step();
        #1;
    endtask

    typedef struct {
        int         py;
        logic [3:0] rq;
        logic [3:0] dn;
        logic [3:0] g;
        logic       w;
        logic [7:0] f;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int py;
        bit bad;
        logic [3:0] eg;

        tbl[0]  = '{480, 4'b0000, 4'b0000, 4'b0000, 1'b1, 8'd1};
        tbl[1]  = '{480, 4'b1111, 4'b0000, 4'b0000, 1'b1, 8'd1};
        tbl[2]  = '{480, 4'b1111, 4'b0000, 4'b0001, 1'b1, 8'd1};
        tbl[3]  = '{480, 4'b1111, 4'b0001, 4'b0000, 1'b1, 8'd1};
        tbl[4]  = '{480, 4'b1111, 4'b0000, 4'b0010, 1'b1, 8'd1};
        tbl[5]  = '{480, 4'b1111, 4'b0010, 4'b0000, 1'b1, 8'd1};
        tbl[6]  = '{480, 4'b1111, 4'b0000, 4'b0100, 1'b1, 8'd1};
        tbl[7]  = '{480, 4'b1111, 4'b0100, 4'b0000, 1'b1, 8'd1};
        tbl[8]  = '{480, 4'b1111, 4'b0000, 4'b1000, 1'b1, 8'd1};
        tbl[9]  = '{480, 4'b1111, 4'b1000, 4'b0000, 1'b1, 8'd1};
        tbl[10] = '{480, 4'b1111, 4'b0000, 4'b0001, 1'b1, 8'd1};
        tbl[11] = '{480, 4'b0100, 4'b0001, 4'b0000, 1'b1, 8'd1};
        tbl[12] = '{480, 4'b0100, 4'b0000, 4'b0100, 1'b1, 8'd1};
        tbl[13] = '{480, 4'b0100, 4'b0001, 4'b0100, 1'b1, 8'd1};
        tbl[14] = '{480, 4'b0001, 4'b0000, 4'b0000, 1'b1, 8'd1};
        tbl[15] = '{480, 4'b0001, 4'b0000, 4'b0001, 1'b1, 8'd1};

        // Reset held with all requests and a non-blank line.
        reset  = 1'b0;
        pixely = 10'd100;
        req    = 4'b1111;
        done   = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rst_grant%0d", i), grant, 4'b0000);
            chk($sformatf("rst_frame%0d", i), frame_cnt, 8'd0);
        end
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        chk("idle_grant", grant, 4'b0000);
        chk("idle_window", window, 1'b0);
        chk("idle_frame", frame_cnt, 8'd0);

        // Window entry, round-robin sequence, latency, ignored strobe.
        for (int i = 0; i < 16; i++) begin
            pixely = 10'(tbl[i].py);
            req    = tbl[i].rq;
            done   = tbl[i].dn;
            tick();
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
            chk($sformatf("tbl%0d_window", i), window, tbl[i].w);
            chk($sformatf("tbl%0d_frame", i), frame_cnt, tbl[i].f);
        end

        // Timeout: requester 0 held with no done.
        done = 4'b0000;
        cnt  = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (grant == 4'b0001) cnt++;
            else break;
        end
        chk("to_hold_cycles", cnt, MH);
        chk("to_pulse", timeout, 1'b1);
        chk("to_grant_low", grant, 4'b0000);
        tick();
        chk("to_regrant", grant, 4'b0001);
        chk("to_pulse_end", timeout, 1'b0);

        // Revoke when the guard band starts.
        pixely = 10'd523;
        tick();
        chk("rv_window", window, 1'b0);
        chk("rv_grant_hold", grant, 4'b0001);
        tick();
        chk("rv_grant", grant, 4'b0000);
        chk("rv_pulse", revoked, 1'b1);
        chk("rv_no_to", timeout, 1'b0);

        // No grants outside the window.
        req = 4'b1111;
        bad = 0;
        for (int k = 0; k < 482; k++) begin
            pixely = (k < 2) ? 10'(523 + k) : 10'(k - 2);
            tick();
            if (grant != 4'b0000 || revoked || timeout) bad = 1;
        end
        chk("blank_quiet", bad, 1'b0);

        // Next window: pointer is 1 after the revoke.
        pixely = 10'd480;
        tick();
        chk("w2_window", window, 1'b1);
        chk("w2_frame", frame_cnt, 8'd2);
        tick();
        chk("w2_arb", grant, 4'b0000);
        tick();
        chk("w2_grant", grant, 4'b0010);
        done = 4'b0001;
        tick();
        chk("ign_done", grant, 4'b0010);
        done = 4'b0000;

        // Asynchronous reset in the middle of a grant.
        #2;
        reset = 1'b0;
        #1;
        chk("ar_grant", grant, 4'b0000);
        chk("ar_busy", busy, 1'b0);
        chk("ar_revoked", revoked, 1'b0);
        chk("ar_frame", frame_cnt, 8'd0);
        tick();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (grant != 4'b0000) break;
        end
        chk("ar_first_grant", grant, 4'b0001);
        chk("ar_frame1", frame_cnt, 8'd1);

        // Randomized traffic against the reference model.
        reset = 1'b0;
        req   = 4'b0000;
        done  = 4'b0000;
        tick();
        tick();
        reset = 1'b1;
        py    = 460;
        for (int c = 0; c < 2500; c++) begin
            pixely = 10'(py);
            if ($urandom_range(0, 5) == 0) req = req ^ 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            tick();
            eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
            chk("rnd_grant", grant, eg);
            chk("rnd_window", window, m_win);
            chk("rnd_busy", busy, |eg);
            chk("rnd_timeout", timeout, m_to);
            chk("rnd_revoked", revoked, m_rv);
            chk("rnd_frame", frame_cnt, m_frames);
            if (py >= 470) begin
                if ($urandom_range(0, 1) == 1) py = (py + 1) % 525;
            end else begin
                py = py + 7;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
